// File: rtl/sm_regdump.sv
// Debug register-dump engine: walks debug addresses REG_FIRST..REG_LAST and streams each word out.
// Define SM_REGDUMP_CSUM_EN to append an XOR checksum word after the last register.
module sm_regdump #(
   parameter int REG_FIRST = 0,
   parameter int REG_LAST  = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  regAddr,
   input  logic [31:0] regData,
   output logic [31:0] outData,
   output logic [4:0]  outIndex,
   output logic        outCsum,
   output logic        outLast,
   output logic        outValid,
   input  logic        outReady
);

   localparam logic [4:0] FIRST = 5'(REG_FIRST);
   localparam logic [4:0] LAST  = 5'(REG_LAST);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SAMPLE = 3'd1,
      S_SEND   = 3'd2,
      S_CSUM   = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t      state_q;
   logic [4:0]  idx_q;
   logic        busy_q;
   logic        done_q;
   logic [4:0]  reg_addr_q;
   logic [31:0] out_data_q;
   logic [4:0]  out_index_q;
   logic        out_last_q;
   logic        out_valid_q;

   logic [4:0]  idx_inc_d;
   logic        at_last_d;
   logic        xfer_d;

`ifdef SM_REGDUMP_CSUM_EN
   logic [31:0] csum_q;
   logic        out_csum_q;
   assign outCsum = out_csum_q;
`else
   assign outCsum = 1'b0;
`endif

   assign idx_inc_d = idx_q + 5'd1;
   assign at_last_d = (idx_q == LAST);

   // Sink handshake: a word transfers on any edge where outValid and outReady are both high;
   // until then outValid stays up and outData/outIndex/outLast are frozen.
   assign xfer_d = out_valid_q & outReady;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         idx_q       <= FIRST;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         reg_addr_q  <= 5'd0;
         out_data_q  <= 32'd0;
         out_index_q <= 5'd0;
         out_last_q  <= 1'b0;
         out_valid_q <= 1'b0;
`ifdef SM_REGDUMP_CSUM_EN
         csum_q      <= 32'd0;
         out_csum_q  <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  idx_q      <= FIRST;
                  reg_addr_q <= FIRST;
                  busy_q     <= 1'b1;
                  state_q    <= S_SAMPLE;
`ifdef SM_REGDUMP_CSUM_EN
                  csum_q     <= 32'd0;
`endif
               end
            end

            S_SAMPLE: begin
               // regData is combinational from regAddr, so it is valid in this same cycle.
               out_data_q  <= regData;
               out_index_q <= idx_q;
               out_valid_q <= 1'b1;
               state_q     <= S_SEND;
`ifdef SM_REGDUMP_CSUM_EN
               out_last_q  <= 1'b0;
               csum_q      <= csum_q ^ regData;
`else
               out_last_q  <= at_last_d;
`endif
            end

            S_SEND: begin
               if (xfer_d) begin
                  if (!at_last_d) begin
                     out_valid_q <= 1'b0;
                     idx_q       <= idx_inc_d;
                     reg_addr_q  <= idx_inc_d;
                     state_q     <= S_SAMPLE;
                  end else begin
`ifdef SM_REGDUMP_CSUM_EN
                     out_data_q  <= csum_q;
                     out_index_q <= 5'd0;
                     out_last_q  <= 1'b1;
                     out_csum_q  <= 1'b1;
                     state_q     <= S_CSUM;
`else
                     out_valid_q <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= S_DONE;
`endif
                  end
               end
            end

`ifdef SM_REGDUMP_CSUM_EN
            S_CSUM: begin
               if (xfer_d) begin
                  out_valid_q <= 1'b0;
                  out_csum_q  <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
`endif

            S_DONE: begin
               done_q     <= 1'b0;
               busy_q     <= 1'b0;
               reg_addr_q <= 5'd0;
               state_q    <= S_IDLE;
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign regAddr  = reg_addr_q;
   assign outData  = out_data_q;
   assign outIndex = out_index_q;
   assign outLast  = out_last_q;
   assign outValid = out_valid_q;

endmodule

// File: tb/tb_sm_regdump.sv
// Testbench for sm_regdump: three instances (full range, 1..3, 31..31) with a regData = 0x100 + regAddr model.
module tb_sm_regdump;

   logic            clk;
   logic            rst;
   logic [2:0]      start_v;
   logic [2:0]      ready_v;
   logic [2:0]      busy_v;
   logic [2:0]      done_v;
   logic [2:0]      csum_v;
   logic [2:0]      last_v;
   logic [2:0]      valid_v;
   logic [2:0][4:0]  addr_v;
   logic [2:0][4:0]  idx_v;
   logic [2:0][31:0] rdata_v;
   logic [2:0][31:0] data_v;

   int checks;
   int errors;

   // Word tuple {csum, last, index, data}.
   logic [38:0] exp_q[$];
   logic [38:0] obs_q[$];
   int          done_cyc;
   int          done_cnt;
   int          busy_after;
   int          stall_seen;
   int          stall_bad;

   assign rdata_v[0] = 32'h100 + {27'd0, addr_v[0]};
   assign rdata_v[1] = 32'h100 + {27'd0, addr_v[1]};
   assign rdata_v[2] = 32'h100 + {27'd0, addr_v[2]};

   sm_regdump #(.REG_FIRST(0), .REG_LAST(31)) u_dut0 (
      .clk(clk), .rst(rst), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
      .regAddr(addr_v[0]), .regData(rdata_v[0]), .outData(data_v[0]), .outIndex(idx_v[0]),
      .outCsum(csum_v[0]), .outLast(last_v[0]), .outValid(valid_v[0]), .outReady(ready_v[0]));

   sm_regdump #(.REG_FIRST(1), .REG_LAST(3)) u_dut1 (
      .clk(clk), .rst(rst), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
      .regAddr(addr_v[1]), .regData(rdata_v[1]), .outData(data_v[1]), .outIndex(idx_v[1]),
      .outCsum(csum_v[1]), .outLast(last_v[1]), .outValid(valid_v[1]), .outReady(ready_v[1]));

   sm_regdump #(.REG_FIRST(31), .REG_LAST(31)) u_dut2 (
      .clk(clk), .rst(rst), .start(start_v[2]), .busy(busy_v[2]), .done(done_v[2]),
      .regAddr(addr_v[2]), .regData(rdata_v[2]), .outData(data_v[2]), .outIndex(idx_v[2]),
      .outCsum(csum_v[2]), .outLast(last_v[2]), .outValid(valid_v[2]), .outReady(ready_v[2]));

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

`ifdef SM_REGDUMP_CSUM_EN
   localparam int CSUM_ON = 1;
`else
   localparam int CSUM_ON = 0;
`endif

   // Expected stream for a dump of first..last.
   task automatic build_exp(input int first, input int last);
      logic [31:0] w;
      logic [31:0] x;
      exp_q.delete();
      x = 32'd0;
      for (int i = first; i <= last; i++) begin
         w = 32'h100 + 32'(i);
         x = x ^ w;
         exp_q.push_back({1'b0, (CSUM_ON == 0) && (i == last), 5'(i), w});
      end
      if (CSUM_ON != 0) exp_q.push_back({1'b1, 1'b1, 5'd0, x});
   endtask

   // Driver + monitor: pulse start on instance d, then watch max_cyc cycles.
   task automatic run_dump(input int d, input int max_cyc, input int stall_word,
                           input int stall_len, input bit repulse);
      logic [31:0] held_data;
      logic [4:0]  held_idx;
      logic [4:0]  held_addr;
      held_data = '0;
      held_idx = '0;
      held_addr = '0;
      obs_q.delete();
      done_cyc = -1;
      done_cnt = 0;
      busy_after = -1;
      stall_seen = 0;
      stall_bad = 0;
      start_v[d] = 1'b1;
      step();
      start_v[d] = 1'b0;
      for (int cyc = 1; cyc <= max_cyc; cyc++) begin
         ready_v[d] = 1'b1;
         if (done_v[d]) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = cyc;
            if (repulse) start_v[d] = 1'b1;
         end
         if (done_cyc >= 0 && cyc == done_cyc + 1) busy_after = int'(busy_v[d]);
         if (valid_v[d] && obs_q.size() == stall_word && stall_seen < stall_len) begin
            if (stall_seen == 0) begin
               held_data = data_v[d];
               held_idx  = idx_v[d];
               held_addr = addr_v[d];
            end else if (data_v[d] != held_data || idx_v[d] != held_idx || addr_v[d] != held_addr) begin
               stall_bad++;
            end
            ready_v[d] = 1'b0;
            stall_seen++;
         end
         if (repulse && valid_v[d] && obs_q.size() == 1) start_v[d] = 1'b1;
         if (valid_v[d] && ready_v[d])
            obs_q.push_back({csum_v[d], last_v[d], idx_v[d], data_v[d]});
         step();
         start_v[d] = 1'b0;
      end
      ready_v[d] = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      checks++; if (busy_v[0] !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b exp 0", busy_v[0]); end
      checks++; if (done_v[0] !== 1'b0) begin errors++; $display("FAIL reset_done got %0b exp 0", done_v[0]); end
      checks++; if (addr_v[0] !== 5'd0) begin errors++; $display("FAIL reset_regaddr got %0d exp 0", addr_v[0]); end
      checks++; if (data_v[0] !== 32'd0) begin errors++; $display("FAIL reset_outdata got %h exp 0", data_v[0]); end
      checks++; if (idx_v[0] !== 5'd0) begin errors++; $display("FAIL reset_outindex got %0d exp 0", idx_v[0]); end
      checks++; if ({csum_v[0], last_v[0], valid_v[0]} !== 3'b000) begin
         errors++; $display("FAIL reset_flags got csum/last/valid %03b exp 000", {csum_v[0], last_v[0], valid_v[0]});
      end
      // rst and start together: rst wins.
      rst = 1'b1;
      start_v[0] = 1'b1;
      step();
      rst = 1'b0;
      start_v[0] = 1'b0;
      step();
      checks++; if (busy_v[0] !== 1'b0 || valid_v[0] !== 1'b0) begin
         errors++; $display("FAIL rst_start_busy got busy %0b valid %0b exp 0 0", busy_v[0], valid_v[0]);
      end
   endtask

   task automatic test_full_dump();
      build_exp(0, 31);
      run_dump(0, 75, -1, 0, 1'b0);
      checks++; if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL full_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL full_word[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++; if (done_cyc != 65 + CSUM_ON) begin
         errors++; $display("FAIL full_done_cycle got %0d exp %0d", done_cyc, 65 + CSUM_ON);
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL full_done_count got %0d exp 1", done_cnt); end
      checks++; if (busy_after != 0) begin errors++; $display("FAIL full_busy_after got %0d exp 0", busy_after); end
   endtask

   task automatic test_small_range();
      build_exp(1, 3);
      run_dump(1, 20, -1, 0, 1'b0);
      checks++; if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL small_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL small_word[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++; if (done_cyc != 7 + CSUM_ON) begin
         errors++; $display("FAIL small_done_cycle got %0d exp %0d", done_cyc, 7 + CSUM_ON);
      end
   endtask

   task automatic test_backpressure();
      build_exp(0, 31);
      run_dump(0, 80, 1, 5, 1'b0);
      checks++; if (stall_seen != 5) begin errors++; $display("FAIL bp_stall_cycles got %0d exp 5", stall_seen); end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_hold got %0d changes exp 0", stall_bad); end
      checks++; if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL bp_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL bp_word[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++; if (done_cyc != 70 + CSUM_ON) begin
         errors++; $display("FAIL bp_done_cycle got %0d exp %0d", done_cyc, 70 + CSUM_ON);
      end
   endtask

   task automatic test_start_ignored();
      build_exp(1, 3);
      run_dump(1, 25, -1, 0, 1'b1);
      checks++; if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL repulse_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL repulse_done_count got %0d exp 1", done_cnt); end
      checks++; if (busy_after != 0) begin errors++; $display("FAIL repulse_busy_after got %0d exp 0", busy_after); end
   endtask

   task automatic test_reset_mid();
      bit found;
      found = 1'b0;
      start_v[0] = 1'b1;
      step();
      start_v[0] = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         if (valid_v[0] && idx_v[0] == 5'd7) found = 1'b1;
         else step();
      end
      checks++; if (!found) begin errors++; $display("FAIL midrst_reach_idx7 got none exp index 7 within 40 cycles"); end
      rst = 1'b1;
      step();
      checks++; if (valid_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
         errors++; $display("FAIL midrst_valid_busy got %0b %0b exp 0 0", valid_v[0], busy_v[0]);
      end
      checks++; if (addr_v[0] !== 5'd0 || done_v[0] !== 1'b0) begin
         errors++; $display("FAIL midrst_addr_done got %0d %0b exp 0 0", addr_v[0], done_v[0]);
      end
      rst = 1'b0;
      step();
      checks++; if (done_v[0] !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %0b exp 0", done_v[0]); end
      build_exp(0, 31);
      run_dump(0, 75, -1, 0, 1'b0);
      checks++; if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL midrst_restart_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      checks++; if (obs_q.size() == 0 || obs_q[0] !== exp_q[0]) begin
         errors++; $display("FAIL midrst_restart_first got %h exp %h", (obs_q.size() != 0) ? obs_q[0] : 39'h0, exp_q[0]);
      end
   endtask

   task automatic test_top_index();
      build_exp(31, 31);
      run_dump(2, 12, -1, 0, 1'b0);
      checks++; if (obs_q.size() != exp_q.size()) begin
         errors++; $display("FAIL top_count got %0d exp %0d", obs_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin
            errors++; $display("FAIL top_word[%0d] got %h exp %h", i, obs_q[i], exp_q[i]);
         end
      end
      checks++; if (done_cyc != 3 + CSUM_ON) begin
         errors++; $display("FAIL top_done_cycle got %0d exp %0d", done_cyc, 3 + CSUM_ON);
      end
      checks++; if (done_cnt != 1) begin errors++; $display("FAIL top_done_count got %0d exp 1", done_cnt); end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b1;
      start_v = 3'b000;
      ready_v = 3'b111;
      test_reset();
      test_full_dump();
      test_small_range();
      test_backpressure();
      test_start_ignored();
      test_reset_mid();
      test_top_index();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
